// File: rtl/predictor_salto.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : predictor_salto                                              |
// | Description : RV32I conditional-branch resolver with a saturating-counter  |
// |               predictor table and resolved/mispredicted branch counters.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module predictor_salto #(
    parameter int W         = 32,
    parameter int ENTRADAS  = 16,
    parameter int CONT_BITS = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     pc_fetch,
    output logic             pred_salto,
    input  logic             valido,
    input  logic [W-1:0]     instruccion,
    input  logic [W-1:0]     pc_ex,
    input  logic [W-1:0]     dato_a,
    input  logic [W-1:0]     dato_b,
    input  logic             pred_ex,
    output logic             es_salto,
    output logic             salto,
    output logic             fallo,
    output logic [CNT_W-1:0] cuenta_saltos,
    output logic [CNT_W-1:0] cuenta_fallos
);

    localparam int                   c_idx      = $clog2(ENTRADAS);
    localparam logic [CONT_BITS-1:0] c_cont_ini = CONT_BITS'((2 ** (CONT_BITS - 1)) - 1);
    localparam logic [CONT_BITS-1:0] c_cont_max = '1;
    localparam logic [CONT_BITS-1:0] c_cont_min = '0;
    localparam logic [CNT_W-1:0]     c_cnt_max  = '1;
    localparam logic [6:0]           c_op_branch = 7'b1100011;

    logic [CONT_BITS-1:0] r_tabla [ENTRADAS];
    logic [CNT_W-1:0]     r_cuenta_saltos;
    logic [CNT_W-1:0]     r_cuenta_fallos;

    logic [c_idx-1:0]     w_idx_fetch;
    logic [c_idx-1:0]     w_idx_ex;
    logic [CONT_BITS-1:0] w_cont_ex;
    logic                 w_opcode_ok;
    logic                 w_funct3_ok;
    logic                 w_cond;
    logic                 w_es_salto;
    logic                 w_salto;
    logic                 w_fallo;
    logic                 w_unused;

    // Word-aligned PCs: drop the two low bits, no tag, so aliasing is expected.
    assign w_idx_fetch = pc_fetch[c_idx+1:2];
    assign w_idx_ex    = pc_ex[c_idx+1:2];
    assign w_cont_ex   = r_tabla[w_idx_ex];

    assign w_opcode_ok = (instruccion[6:0] == c_op_branch);

    always_comb begin
        w_funct3_ok = 1'b1;
        w_cond      = 1'b0;
        case (instruccion[14:12])
            3'b000:  w_cond = (dato_a == dato_b);
            3'b001:  w_cond = (dato_a != dato_b);
            3'b100:  w_cond = ($signed(dato_a) <  $signed(dato_b));
            3'b101:  w_cond = ($signed(dato_a) >= $signed(dato_b));
            3'b110:  w_cond = (dato_a <  dato_b);
            3'b111:  w_cond = (dato_a >= dato_b);
            default: w_funct3_ok = 1'b0;
        endcase
    end

    assign w_es_salto = valido & w_opcode_ok & w_funct3_ok;
    assign w_salto    = w_es_salto & w_cond;
    assign w_fallo    = w_es_salto & (w_salto != pred_ex);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRADAS; i++) begin
                r_tabla[i] <= c_cont_ini;
            end
            r_cuenta_saltos <= '0;
            r_cuenta_fallos <= '0;
        end else begin
            if (w_es_salto) begin
                if (w_salto && (w_cont_ex != c_cont_max)) begin
                    r_tabla[w_idx_ex] <= w_cont_ex + CONT_BITS'(1);
                end else if (!w_salto && (w_cont_ex != c_cont_min)) begin
                    r_tabla[w_idx_ex] <= w_cont_ex - CONT_BITS'(1);
                end
                if (r_cuenta_saltos != c_cnt_max) begin
                    r_cuenta_saltos <= r_cuenta_saltos + CNT_W'(1);
                end
            end
            if (w_fallo && (r_cuenta_fallos != c_cnt_max)) begin
                r_cuenta_fallos <= r_cuenta_fallos + CNT_W'(1);
            end
        end
    end

    // Asynchronous read gives read-before-write when fetch and execute collide.
    assign pred_salto    = r_tabla[w_idx_fetch][CONT_BITS-1];
    assign es_salto      = w_es_salto;
    assign salto         = w_salto;
    assign fallo         = w_fallo;
    assign cuenta_saltos = r_cuenta_saltos;
    assign cuenta_fallos = r_cuenta_fallos;

    // PC bits outside the index and instruction fields other than opcode/funct3.
    assign w_unused = ^{pc_fetch, pc_ex, instruccion};

endmodule
`default_nettype wire
